pipe_hazard_ctrl: RTL
=====================

Name: pipe_hazard_ctrl

Overview:
Central pipeline controller for the 5-stage core. It generates the stall, nop and flush controls for the ID/EX pipeline register, and the hold controls for PC and IF/ID. It sequences four cases: load-use bubbles, multi-cycle MDU operations, LSU back-pressure, and EX-stage branch/jump redirects. A small FSM and counters hold the pipeline for the correct number of cycles and count the bubbles it injects.

Parameters:
REDIR_BUBBLES, 2, cycles id_nop is held after a redirect to squash in-flight wrong-path fetches (1..7)
MDU_TIMEOUT, 64, max MDU_WAIT cycles before mdu_err is raised
REG_AW, 5, register address width

Ports:
clock  in  1  core clock
reset  in  1  synchronous, active-high
id_valid  in  1  ID holds a valid instruction
id_rs1_addr  in  REG_AW  ID source 1
id_rs1_use  in  1  ID reads rs1
id_rs2_addr  in  REG_AW  ID source 2
id_rs2_use  in  1  ID reads rs2
ex_w_ena  in  1  EX instruction writes the regfile
ex_w_addr  in  REG_AW  EX destination
ex_is_load  in  1  EX instruction is a load (mem_ena & read)
ex_redirect  in  1  EX resolved a taken branch/jump or mispredict
mdu_start  in  1  EX issued a multi-cycle mul/div (1-cycle pulse)
mdu_done  in  1  MDU result ready (1-cycle pulse)
lsu_busy  in  1  MEM-stage access outstanding
pc_hold  out  1  freeze PC
if_id_hold  out  1  freeze IF/ID register
if_id_flush  out  1  clear IF/ID register
id_ex_stall  out  1  to ID/EX stall (1 = hold EX contents)
id_ex_nop  out  1  to ID/EX nop (load a bubble)
id_ex_flush  out  1  to ID/EX flush
mdu_err  out  1  sticky MDU timeout flag
bubble_cnt  out  32  injected-bubble counter, wraps at 2^32

Behaviour:
- Reset: state=RUN; all outputs 0; redir_cnt=0; mdu_cnt=0; bubble_cnt=0; mdu_err=0. Reset mid-operation aborts any state on the next edge.
- States: RUN, LSU_WAIT, MDU_WAIT, REDIR.
- Load-use hazard (lu_haz) is combinational: id_valid & ex_is_load & ex_w_ena & ex_w_addr!=0 & ((id_rs1_use & id_rs1_addr==ex_w_addr) | (id_rs2_use & id_rs2_addr==ex_w_addr)).
- RUN priority, highest first:
  1. lsu_busy: pc_hold=if_id_hold=id_ex_stall=1 in the same cycle (combinational); next state LSU_WAIT.
  2. ex_redirect: if_id_flush=id_ex_flush=id_ex_nop=1 this cycle; redir_cnt<=REDIR_BUBBLES-1; bubble_cnt+1; next REDIR. If REDIR_BUBBLES=1, stay in RUN.
  3. mdu_start: pc_hold=if_id_hold=id_ex_stall=1; mdu_cnt<=0; next MDU_WAIT.
  4. lu_haz: pc_hold=if_id_hold=id_ex_nop=1 for exactly this cycle; bubble_cnt+1; stay RUN. The bubble clears EX, so lu_haz deasserts the next cycle.
  5. Otherwise all control outputs are 0.
- LSU_WAIT: pc_hold=if_id_hold=id_ex_stall=1 while lsu_busy=1. When lsu_busy=0, outputs drop in that cycle and the state returns to RUN. Redirects and hazards are not evaluated here; EX is frozen, so they re-present in RUN.
- MDU_WAIT: pc_hold=if_id_hold=id_ex_stall=1 and mdu_cnt increments.
  - mdu_done=1: outputs drop in the same cycle (EX advances with the result); next RUN.
  - mdu_cnt==MDU_TIMEOUT-1 without done: mdu_err<=1 (sticky until reset); next RUN.
  - lsu_busy has no effect in this state.
- REDIR: id_ex_nop=1 each cycle and bubble_cnt+1 each cycle; redir_cnt decrements; at redir_cnt==0 next RUN. PC and IF/ID are not held.
  - A new ex_redirect here is ignored: EX holds only bubbles.
  - lsu_busy here takes priority: id_ex_stall=1 and the state moves to LSU_WAIT. redir_cnt is frozen and resumes after LSU_WAIT (return state saved).
- Simultaneous mdu_start & ex_redirect: redirect wins, mdu_start is ignored.
- Simultaneous mdu_done & mdu_start in MDU_WAIT: done is taken; start is not re-armed (protocol violation).
- id_ex_stall and id_ex_nop are never both 1. id_ex_flush always coincides with id_ex_nop.

Test Plan:
- Load-use: EX=lw x5, ID=add x6,x5,x1 -> one cycle with pc_hold=if_id_hold=id_ex_nop=1, bubble_cnt 0->1; next cycle all 0. Same case with ex_w_addr=0 -> no bubble.
- Redirect, REDIR_BUBBLES=2: ex_redirect pulse -> cycle0 flushes+nop, cycle1 nop only, cycle2 all 0; bubble_cnt=2.
- MDU: mdu_start, then mdu_done 10 cycles later -> stall/hold high 10 cycles, low in the done cycle, mdu_err=0. Repeat with no done, MDU_TIMEOUT=64 -> return to RUN after 64 cycles, mdu_err=1 until reset.
- LSU: lsu_busy high 5 cycles with ex_redirect and lu_haz also asserted -> stall/holds high 5 cycles, no nop/flush. After release, the redirect sequence runs.
- Redirect during REDIR with lsu_busy for 3 cycles -> redir_cnt frozen, id_ex_stall=1 for those 3 cycles, then the remaining bubble is issued; total bubble_cnt=2.
- Reset asserted in MDU_WAIT and REDIR -> next cycle state=RUN, all outputs 0, bubble_cnt=0.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: load-use bubbles, MDU waits, LSU back-pressure and
// EX redirects, driving PC/IF-ID holds and ID/EX stall/nop/flush plus a bubble counter.
module pipe_hazard_ctrl #(
  parameter int unsigned REDIR_BUBBLES = 2,
  parameter int unsigned MDU_TIMEOUT   = 64,
  parameter int unsigned REG_AW        = 5
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs1_addr,
  input  logic              id_rs1_use,
  input  logic [REG_AW-1:0] id_rs2_addr,
  input  logic              id_rs2_use,
  input  logic              ex_w_ena,
  input  logic [REG_AW-1:0] ex_w_addr,
  input  logic              ex_is_load,
  input  logic              ex_redirect,
  input  logic              mdu_start,
  input  logic              mdu_done,
  input  logic              lsu_busy,
  output logic              pc_hold,
  output logic              if_id_hold,
  output logic              if_id_flush,
  output logic              id_ex_stall,
  output logic              id_ex_nop,
  output logic              id_ex_flush,
  output logic              mdu_err,
  output logic [31:0]       bubble_cnt
);

  localparam int unsigned RCW = 3;
  localparam int unsigned MCW = (MDU_TIMEOUT > 1) ? $clog2(MDU_TIMEOUT) : 1;
  localparam bit MULTI_BUBBLE = (REDIR_BUBBLES > 1);

  typedef enum logic [1:0] {RUN, LSU_WAIT, MDU_WAIT, REDIR} state_t;

  state_t         state, state_nxt;
  logic           ret_redir;
  logic [RCW-1:0] redir_cnt;
  logic [MCW-1:0] mdu_cnt;
  logic           lu_haz;
  logic           mdu_expired;
  logic           redir_last;
  logic           bubble_inc;

  assign lu_haz = id_valid & ex_is_load & ex_w_ena & (ex_w_addr != '0) &
                  ((id_rs1_use & (id_rs1_addr == ex_w_addr)) |
                   (id_rs2_use & (id_rs2_addr == ex_w_addr)));
  assign mdu_expired = (mdu_cnt == MCW'(MDU_TIMEOUT - 1));
  assign redir_last  = (redir_cnt <= RCW'(1));

  // State register
  always_ff @(posedge clock) begin
    if (reset) state <= RUN;
    else       state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      RUN: begin
        if (lsu_busy)         state_nxt = LSU_WAIT;
        else if (ex_redirect) state_nxt = MULTI_BUBBLE ? REDIR : RUN;
        else if (mdu_start)   state_nxt = MDU_WAIT;
      end
      LSU_WAIT: if (!lsu_busy) state_nxt = ret_redir ? REDIR : RUN;
      MDU_WAIT: if (mdu_done || mdu_expired) state_nxt = RUN;
      REDIR: begin
        if (lsu_busy)        state_nxt = LSU_WAIT;
        else if (redir_last) state_nxt = RUN;
      end
      default: state_nxt = RUN;
    endcase
  end

  // Control outputs; combinational so the pipeline reacts in the hazard cycle itself
  always_comb begin
    pc_hold     = 1'b0;
    if_id_hold  = 1'b0;
    if_id_flush = 1'b0;
    id_ex_stall = 1'b0;
    id_ex_nop   = 1'b0;
    id_ex_flush = 1'b0;
    bubble_inc  = 1'b0;
    if (!reset) begin
      case (state)
        RUN: begin
          if (lsu_busy || (!ex_redirect && mdu_start)) begin
            pc_hold     = 1'b1;
            if_id_hold  = 1'b1;
            id_ex_stall = 1'b1;
          end else if (ex_redirect) begin
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
            id_ex_nop   = 1'b1;
            bubble_inc  = 1'b1;
          end else if (lu_haz) begin
            pc_hold    = 1'b1;
            if_id_hold = 1'b1;
            id_ex_nop  = 1'b1;
            bubble_inc = 1'b1;
          end
        end
        LSU_WAIT, MDU_WAIT: begin
          if ((state == LSU_WAIT) ? lsu_busy : !mdu_done) begin
            pc_hold     = 1'b1;
            if_id_hold  = 1'b1;
            id_ex_stall = 1'b1;
          end
        end
        REDIR: begin
          if (lsu_busy) begin
            id_ex_stall = 1'b1;
          end else begin
            id_ex_nop  = 1'b1;
            bubble_inc = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Counters, return-state flag and sticky error
  always_ff @(posedge clock) begin
    if (reset) begin
      redir_cnt  <= '0;
      mdu_cnt    <= '0;
      ret_redir  <= 1'b0;
      mdu_err    <= 1'b0;
      bubble_cnt <= '0;
    end else begin
      bubble_cnt <= bubble_cnt + 32'(bubble_inc);
      case (state)
        RUN: begin
          ret_redir <= 1'b0;
          if (!lsu_busy && ex_redirect) redir_cnt <= RCW'(REDIR_BUBBLES - 1);
          if (!lsu_busy && !ex_redirect && mdu_start) mdu_cnt <= '0;
        end
        MDU_WAIT: begin
          mdu_cnt <= mdu_cnt + MCW'(1);
          if (!mdu_done && mdu_expired) mdu_err <= 1'b1;
        end
        REDIR: begin
          if (lsu_busy) ret_redir <= 1'b1;
          else if (redir_cnt != '0) redir_cnt <= redir_cnt - RCW'(1);
        end
        default: ;
      endcase
    end
  end

endmodule
